// File: rtl/pattern_capture_if.sv
// RAM write port driven by the pattern capture block while it owns the RAM.
interface pattern_capture_if #(
   parameter int unsigned RAM_ADDR_BITS = 8
);
   logic [RAM_ADDR_BITS-1:0] ram_addr_pat_cap;
   logic [7:0]               ram_wdata_pat_cap;
   logic                     ram_we_pat_cap;

   modport master (
      output ram_addr_pat_cap,
      output ram_wdata_pat_cap,
      output ram_we_pat_cap
   );

   modport slave (
      input ram_addr_pat_cap,
      input ram_wdata_pat_cap,
      input ram_we_pat_cap
   );
endinterface

// File: rtl/pattern_capture.sv
// Pattern capture: samples 1/2/4/8 pins on a programmable base-10 timestep,
// packs samples MSB-first into bytes and writes them to RAM from address 0.
module pattern_capture #(
   parameter int unsigned RAM_ADDR_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_enable_pat_cap,
   input  logic [RAM_ADDR_BITS-1:0] cfg_end_address_pat_cap,
   input  logic [1:0]               cfg_num_gpio_sel_pat_cap,
   input  logic [2:0]               cfg_timestep_sel_pat_cap,
   input  logic [4:0]               cfg_stage1_count_sel_pat_cap,
   input  logic [1:0]               cfg_trigger_mode_pat_cap,
   input  logic                     trigger_in,
   input  logic [7:0]               gpio_pat_cap_in,
   output logic                     capture_active,
   output logic                     capture_done,
   pattern_capture_if.master        ram
);

   typedef enum logic [1:0] {StIdle, StArm, StCapture, StDone} state_e;

   localparam logic [RAM_ADDR_BITS-1:0] AddrOne = 1;

   state_e                   state_q, state_d;
   logic [7:0]               gpio_s1, gpio_s2;
   logic                     trig_s1, trig_s2, trig_s3;
   logic                     enable_q;
   logic [4:0]               stage1_q;
   logic [25:0]              ts_q;
   logic [2:0]               slot_q;
   logic [7:0]               byte_q, wdata_q;
   logic                     we_q;
   logic [RAM_ADDR_BITS-1:0] addr_q;

   logic        en_rise, trig_hit, cap_run, last_write, tick;
   logic [4:0]  stage1_max;
   logic [25:0] ts_max;
   logic [2:0]  last_slot;
   logic [7:0]  byte_next;
   int          n_pins, slot_base;

   // Edge detection, tick generation and sample packing
   always_comb begin
      en_rise    = cfg_enable_pat_cap & ~enable_q;
      trig_hit   = 1'b0;
      unique case (cfg_trigger_mode_pat_cap)
         2'b01:   trig_hit = trig_s2 & ~trig_s3;
         2'b10:   trig_hit = ~trig_s2 & trig_s3;
         2'b11:   trig_hit = trig_s2 ^ trig_s3;
         default: trig_hit = 1'b0;
      endcase
      cap_run    = (state_q == StCapture) && cfg_enable_pat_cap;
      // Final byte is on the bus this cycle; stop sampling so nothing follows it
      last_write = we_q && (addr_q == cfg_end_address_pat_cap);
      stage1_max = (cfg_stage1_count_sel_pat_cap <= 5'd1) ? 5'd0
                                                        : cfg_stage1_count_sel_pat_cap - 5'd1;
      ts_max     = 26'd0;
      unique case (cfg_timestep_sel_pat_cap)
         3'd0: ts_max = 26'd0;
         3'd1: ts_max = 26'd9;
         3'd2: ts_max = 26'd99;
         3'd3: ts_max = 26'd999;
         3'd4: ts_max = 26'd9999;
         3'd5: ts_max = 26'd99999;
         3'd6: ts_max = 26'd999999;
         3'd7: ts_max = 26'd9999999;
         default: ts_max = 26'd0;
      endcase
      tick = cap_run && !last_write && (stage1_q == stage1_max) && (ts_q == ts_max);
      n_pins    = 1;
      last_slot = 3'd7;
      unique case (cfg_num_gpio_sel_pat_cap)
         2'b00: begin n_pins = 1; last_slot = 3'd7; end
         2'b01: begin n_pins = 2; last_slot = 3'd3; end
         2'b10: begin n_pins = 4; last_slot = 3'd1; end
         2'b11: begin n_pins = 8; last_slot = 3'd0; end
         default: begin n_pins = 1; last_slot = 3'd7; end
      endcase
      slot_base = int'(slot_q) * n_pins;
      byte_next = byte_q;
      for (int j = 0; j < 8; j++) begin
         if (j < n_pins) byte_next[3'(7 - slot_base - j)] = gpio_s2[j];
      end
   end

   // Next-state and status outputs; dropping enable overrides everything
   always_comb begin
      state_d        = state_q;
      capture_active = 1'b0;
      capture_done   = 1'b0;
      if (!cfg_enable_pat_cap) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (en_rise) state_d = (cfg_trigger_mode_pat_cap == 2'b00) ? StCapture : StArm;
            end
            StArm:     if (trig_hit) state_d = StCapture;
            StCapture: if (last_write) state_d = StDone;
            StDone:    state_d = StDone;
            default:   state_d = StIdle;
         endcase
      end
      capture_active = (state_q == StArm) || (state_q == StCapture);
      capture_done   = (state_q == StDone);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Synchronisers, timestep counters, packing and write pipeline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gpio_s1  <= '0;
         gpio_s2  <= '0;
         trig_s1  <= 1'b0;
         trig_s2  <= 1'b0;
         trig_s3  <= 1'b0;
         enable_q <= 1'b0;
         stage1_q <= '0;
         ts_q     <= '0;
         slot_q   <= '0;
         byte_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
      end else begin
         gpio_s1  <= gpio_pat_cap_in;
         gpio_s2  <= gpio_s1;
         trig_s1  <= trigger_in;
         trig_s2  <= trig_s1;
         trig_s3  <= trig_s2;
         enable_q <= cfg_enable_pat_cap;
         if (!cap_run) begin
            // Also discards any partial byte on abort
            stage1_q <= '0;
            ts_q     <= '0;
            slot_q   <= '0;
            byte_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
         end else begin
            if (stage1_q == stage1_max) begin
               stage1_q <= '0;
               ts_q     <= (ts_q == ts_max) ? 26'd0 : ts_q + 26'd1;
            end else begin
               stage1_q <= stage1_q + 5'd1;
            end
            we_q <= 1'b0;
            if (tick) begin
               if (slot_q == last_slot) begin
                  wdata_q <= byte_next;
                  we_q    <= 1'b1;
                  byte_q  <= '0;
                  slot_q  <= '0;
               end else begin
                  byte_q <= byte_next;
                  slot_q <= slot_q + 3'd1;
               end
            end
            if (we_q && !last_write) addr_q <= addr_q + AddrOne;
         end
      end
   end

   // RAM port: strobe and address forced low the moment capture is aborted
   always_comb begin
      ram.ram_we_pat_cap    = cap_run & we_q;
      ram.ram_addr_pat_cap  = cap_run ? addr_q : '0;
      ram.ram_wdata_pat_cap = wdata_q;
   end

endmodule

// File: tb/tb_pattern_capture.sv
// Directed bench for pattern_capture with a write scoreboard.
module tb_pattern_capture;
   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic [AW-1:0] end_addr;
   logic [1:0]    num_sel;
   logic [2:0]    ts_sel;
   logic [4:0]    st1_sel;
   logic [1:0]    trig_mode;
   logic          trig;
   logic [7:0]    gpio;
   logic          active, done;

   pattern_capture_if #(.RAM_ADDR_BITS(AW)) ifc ();

   pattern_capture #(.RAM_ADDR_BITS(AW)) dut (
      .clk                          (clk),
      .rst_n                        (rst_n),
      .cfg_enable_pat_cap           (enable),
      .cfg_end_address_pat_cap      (end_addr),
      .cfg_num_gpio_sel_pat_cap     (num_sel),
      .cfg_timestep_sel_pat_cap     (ts_sel),
      .cfg_stage1_count_sel_pat_cap (st1_sel),
      .cfg_trigger_mode_pat_cap     (trig_mode),
      .trigger_in                   (trig),
      .gpio_pat_cap_in              (gpio),
      .capture_active               (active),
      .capture_done                 (done),
      .ram                          (ifc.master)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_q[$];   // {addr, data}
   int unsigned wr_cyc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag, input int lim);
      for (int i = 0; i < lim && done !== 1'b1; i++) step();
      chk(tag, 32'(done), 32'd1);
   endtask

   task automatic chk_wr(input string tag, input int unsigned want);
      int unsigned got;
      got = 32'hffff_ffff;
      if (wr_cyc.size() != 0) got = wr_cyc.pop_front();
      chk(tag, got, want);
   endtask

   // Scoreboard: every RAM write must match the oldest expected entry
   always @(negedge clk) begin
      if (rst_n === 1'b1 && ifc.ram_we_pat_cap === 1'b1) begin
         wr_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_write observed=%0h:%0h expected=none",
                   ifc.ram_addr_pat_cap, ifc.ram_wdata_pat_cap);
         end else begin
            chk("write", {16'h0, ifc.ram_addr_pat_cap, ifc.ram_wdata_pat_cap},
                {16'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      logic [7:0]  pat;
      int unsigned c, t;
      pat = 8'b1010_0101;
      rst_n = 1'b0; enable = 1'b0; end_addr = '0; num_sel = 2'b00; ts_sel = 3'd0;
      st1_sel = 5'd1; trig_mode = 2'b00; trig = 1'b0; gpio = 8'h00;
      step(3);
      chk("rst_active", 32'(active), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_we", 32'(ifc.ram_we_pat_cap), 0);
      chk("rst_addr", 32'(ifc.ram_addr_pat_cap), 0);
      chk("rst_wdata", 32'(ifc.ram_wdata_pat_cap), 0);
      rst_n = 1'b1;
      step();

      // N=1, divide-by-1, pin0 = 1,0,1,0,0,1,0,1 -> 0xA5 at address 0
      exp_q.push_back({8'h00, 8'hA5});
      gpio = {7'b0, pat[7]};
      step();
      enable = 1'b1;
      c = cyc;
      gpio = {7'b0, pat[6]};
      for (int k = 5; k >= 0; k--) begin
         step();
         gpio = {7'b0, pat[k]};
      end
      chk("n1_active", 32'(active), 1);
      wait_done("n1_done", 20);
      chk_wr("n1_wr_cycle", c + 9);
      chk("n1_done_inactive", 32'(active), 0);
      enable = 1'b0;
      step();
      chk("n1_done_cleared", 32'(done), 0);

      // N=8, end=3, one byte per clock with bit reversal
      num_sel = 2'b11; end_addr = 8'd3;
      exp_q.push_back({8'h00, 8'h80});
      exp_q.push_back({8'h01, 8'h40});
      exp_q.push_back({8'h02, 8'h20});
      exp_q.push_back({8'h03, 8'h10});
      gpio = 8'h01;
      step();
      enable = 1'b1;
      c = cyc;
      gpio = 8'h02; step();
      gpio = 8'h04; step();
      gpio = 8'h08; step();
      gpio = 8'h00;
      wait_done("n8_done", 20);
      for (int i = 0; i < 4; i++) chk_wr("n8_wr_cycle", c + 2 + 32'(i));
      chk("n8_done_addr", 32'(ifc.ram_addr_pat_cap), 0);
      enable = 1'b0;
      step(2);

      // N=2, stage1=27, timestep 1: 270 clk per tick, 4 ticks per byte
      num_sel = 2'b01; st1_sel = 5'd27; ts_sel = 3'd1; end_addr = 8'd1; gpio = 8'h02;
      step(3);
      exp_q.push_back({8'h00, 8'h55});
      exp_q.push_back({8'h01, 8'h55});
      enable = 1'b1;
      c = cyc;
      step(269);
      chk("n2_no_early_write", wr_cyc.size(), 0);
      wait_done("n2_done", 3000);
      chk_wr("n2_wr0_cycle", c + 1081);
      chk_wr("n2_wr1_cycle", c + 2161);
      enable = 1'b0;
      step(2);

      // Rising trigger with stage1=3: armed, no writes until the edge
      num_sel = 2'b11; st1_sel = 5'd3; ts_sel = 3'd0; trig_mode = 2'b01; end_addr = 8'd0;
      gpio = 8'h0F;
      step(3);
      exp_q.push_back({8'h00, 8'hF0});
      enable = 1'b1;
      step(10);
      chk("arm_active", 32'(active), 1);
      chk("arm_no_write", wr_cyc.size(), 0);
      chk("arm_not_done", 32'(done), 0);
      trig = 1'b1;
      t = cyc;
      wait_done("trig_done", 30);
      chk_wr("trig_wr_cycle", t + 6);
      enable = 1'b0; trig = 1'b0;
      step(2);

      // Abort after 5 of 8 samples, then restart from address 0
      num_sel = 2'b00; st1_sel = 5'd1; trig_mode = 2'b00; gpio = 8'h00;
      step(3);
      enable = 1'b1;
      step(6);
      enable = 1'b0;
      chk("abort_we", 32'(ifc.ram_we_pat_cap), 0);
      chk("abort_addr", 32'(ifc.ram_addr_pat_cap), 0);
      step();
      chk("abort_idle", 32'(active), 0);
      chk("abort_not_done", 32'(done), 0);
      gpio = 8'h01;
      step(3);
      exp_q.push_back({8'h00, 8'hFF});
      enable = 1'b1;
      c = cyc;
      wait_done("restart_done", 20);
      chk_wr("restart_wr_cycle", c + 9);
      enable = 1'b0;
      step(2);

      // Synchronous reset in the middle of a capture
      ts_sel = 3'd2;
      enable = 1'b1;
      step(30);
      chk("pre_rst_active", 32'(active), 1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_active", 32'(active), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_we", 32'(ifc.ram_we_pat_cap), 0);
      chk("mid_rst_addr", 32'(ifc.ram_addr_pat_cap), 0);
      chk("mid_rst_wdata", 32'(ifc.ram_wdata_pat_cap), 0);
      rst_n = 1'b1; enable = 1'b0;
      step(3);
      chk("post_rst_idle", 32'(active), 0);

      chk("sb_empty", exp_q.size(), 0);
      chk("wr_cyc_empty", wr_cyc.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
